// File: rtl/simeck_pkg.sv
// Shared Simeck definitions used by both the encrypt and decrypt datapaths.
// Holds the cipher constants, the round-function helpers and the state
// encoding for the iterative controllers.
//   simeck_rotl : modular left rotate of a w-bit value held in a wide word
//   simeck_f    : Simeck round function f(x) = (x & rotl(x,5)) ^ rotl(x,1)
package simeck_pkg;

  localparam int SIMECK_ROT_A   = 5;
  localparam int SIMECK_ROT_B   = 1;
  localparam int SIMECK_NROUNDS = 32;
  localparam int SIMECK_DATAW   = 16;

  // The helpers work on a fixed wide carrier so any DATAW up to this width
  // can share them; callers zero-extend in and truncate out.
  localparam int SIMECK_MAXW = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } simeck_state_e;

  // Rotate the low w bits of x left by n; bits above w are kept at zero.
  function automatic logic [SIMECK_MAXW-1:0] simeck_rotl(
    input logic [SIMECK_MAXW-1:0] x,
    input int                     n,
    input int                     w
  );
    logic [SIMECK_MAXW-1:0] mask;
    logic [SIMECK_MAXW-1:0] xm;
    mask = (w >= SIMECK_MAXW) ? '1 : ((SIMECK_MAXW'(1) << w) - SIMECK_MAXW'(1));
    xm   = x & mask;
    return ((xm << n) | (xm >> (w - n))) & mask;
  endfunction

  function automatic logic [SIMECK_MAXW-1:0] simeck_f(
    input logic [SIMECK_MAXW-1:0] x,
    input int                     w
  );
    return (x & simeck_rotl(x, SIMECK_ROT_A, w)) ^ simeck_rotl(x, SIMECK_ROT_B, w);
  endfunction

endpackage

// File: rtl/simeck_inv_round.sv
// Combinational inverse Simeck round.
// Undoes the forward round L' = R ^ f(L) ^ k, R' = L.
//   l_i, r_i  : current word pair
//   k_i       : round key for this round
//   l_new_o   : recovered left word  (= r_i)
//   r_new_o   : recovered right word (= l_i ^ f(r_i) ^ k_i)
module simeck_inv_round
  import simeck_pkg::*;
#(
  parameter int DATAW = SIMECK_DATAW
) (
  input  logic [DATAW-1:0] l_i,
  input  logic [DATAW-1:0] r_i,
  input  logic [DATAW-1:0] k_i,
  output logic [DATAW-1:0] l_new_o,
  output logic [DATAW-1:0] r_new_o
);

  logic [DATAW-1:0] f_r;

  assign f_r     = DATAW'(simeck_f(SIMECK_MAXW'(r_i), DATAW));
  assign l_new_o = r_i;
  assign r_new_o = l_i ^ f_r ^ k_i;

endmodule

// File: rtl/simeck_decrypt.sv
// Iterative Simeck decryption core, one inverse round per clock.
// Round keys are fetched last-to-first through rk_idx/rk.
//   clk, reset   : clock, synchronous active-high reset
//   start        : load ct_l/ct_r and begin (ignored while busy)
//   ct_l, ct_r   : ciphertext word pair
//   rk_idx, rk   : round-key request index and the key returned for it
//   busy         : rounds in progress
//   done         : one-cycle pulse, pt_l/pt_r freshly updated
//   pt_l, pt_r   : plaintext, held until the next completion or reset
module simeck_decrypt
  import simeck_pkg::*;
#(
  parameter int DATAW   = SIMECK_DATAW,
  parameter int NROUNDS = SIMECK_NROUNDS,
  // A single-round build still needs a 1-bit counter.
  parameter int CNTW    = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DATAW-1:0] ct_l,
  input  logic [DATAW-1:0] ct_r,
  output logic [CNTW-1:0]  rk_idx,
  input  logic [DATAW-1:0] rk,
  output logic             busy,
  output logic             done,
  output logic [DATAW-1:0] pt_l,
  output logic [DATAW-1:0] pt_r
);

  localparam logic [CNTW-1:0] LAST_RND = CNTW'(NROUNDS - 1);

  simeck_state_e    state_q, state_d;
  logic [DATAW-1:0] l_q, l_d;
  logic [DATAW-1:0] r_q, r_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DATAW-1:0] pt_l_q, pt_l_d;
  logic [DATAW-1:0] pt_r_q, pt_r_d;
  logic [DATAW-1:0] l_new, r_new;

  simeck_inv_round #(
    .DATAW (DATAW)
  ) u_round (
    .l_i     (l_q),
    .r_i     (r_q),
    .k_i     (rk),
    .l_new_o (l_new),
    .r_new_o (r_new)
  );

  // While idle the index already points at the last key so the first
  // round sees a settled key the moment it starts.
  assign rk_idx = (state_q == RUN) ? (LAST_RND - cnt_q) : LAST_RND;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign pt_l   = pt_l_q;
  assign pt_r   = pt_r_q;

  // State register: everything clears together on reset, which also
  // discards any partially decrypted block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pt_l_q  <= '0;
      pt_r_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pt_l_q  <= pt_l_d;
      pt_r_q  <= pt_r_d;
    end
  end

  // Next-state logic. done defaults low so it can only ever be a single
  // cycle pulse; the plaintext registers hold unless a run completes.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pt_l_d  = pt_l_q;
    pt_r_d  = pt_r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = ct_l;
          r_d     = ct_r;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d = l_new;
        r_d = r_new;
        if (cnt_q == LAST_RND) begin
          pt_l_d  = l_new;
          pt_r_d  = r_new;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_simeck_decrypt.sv
// Testbench for simeck_decrypt: a 32-round instance backed by a round-key
// store, plus a 1-round instance with its key tied to zero. Expected values
// come from a plain encryption model and the Simeck32/64 key schedule.
module tb_simeck_decrypt;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ct_l, ct_r, rk, pt_l, pt_r;
  logic [4:0]  rk_idx;
  logic        busy, done;

  logic        start1;
  logic [15:0] ct1_l, ct1_r, pt1_l, pt1_r;
  logic [0:0]  rkIdx1;
  logic        busy1, done1;

  logic [15:0] rkStore [32];

  int testsRun    = 0;
  int testsFailed = 0;

  simeck_decrypt #(.DATAW(16), .NROUNDS(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ct_l   (ct_l),
    .ct_r   (ct_r),
    .rk_idx (rk_idx),
    .rk     (rk),
    .busy   (busy),
    .done   (done),
    .pt_l   (pt_l),
    .pt_r   (pt_r)
  );

  simeck_decrypt #(.DATAW(16), .NROUNDS(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .start  (start1),
    .ct_l   (ct1_l),
    .ct_r   (ct1_r),
    .rk_idx (rkIdx1),
    .rk     (16'h0000),
    .busy   (busy1),
    .done   (done1),
    .pt_l   (pt1_l),
    .pt_r   (pt1_r)
  );

  // Key store answers combinationally for whatever index is requested.
  assign rk = rkStore[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference round function with explicit bit rotations.
  function automatic logic [15:0] fRef(input logic [15:0] x);
    return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
  endfunction

  // Simeck32/64 key schedule: fills rkStore from a 64-bit master key.
  task automatic genKeys(input logic [63:0] mk);
    logic [15:0] k [4];
    logic [31:0] seq;
    logic [15:0] c, tmp;
    k[0] = mk[15:0];
    k[1] = mk[31:16];
    k[2] = mk[47:32];
    k[3] = mk[63:48];
    seq  = 32'h9A42BB1F;
    for (int i = 0; i < 32; i++) begin
      rkStore[i] = k[0];
      c   = 16'hFFFC | {15'd0, seq[0]};
      seq = seq >> 1;
      tmp  = k[1];
      k[1] = fRef(k[1]) ^ k[0] ^ c;
      k[0] = tmp;
      tmp  = k[1];
      k[1] = k[2];
      k[2] = k[3];
      k[3] = tmp;
    end
  endtask

  // Forward encryption with the current key store; returns {L, R}.
  function automatic logic [31:0] encryptRef(input logic [15:0] pl, input logic [15:0] pr);
    logic [15:0] l, r, t;
    l = pl;
    r = pr;
    for (int i = 0; i < 32; i++) begin
      t = l;
      l = fRef(l) ^ r ^ rkStore[i];
      r = t;
    end
    return {l, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse and waits (bounded) for done. Returns the number
  // of edges from the start edge to the done cycle (-1 on timeout), the
  // number of busy cycles seen, and how many rk_idx values were off the
  // expected descending sequence. Leaves the bench in the done cycle.
  task automatic applyStimulus(input logic [15:0] cl, input logic [15:0] cr,
                               output int latency, output int busyCycles,
                               output int rkErrors);
    int expIdx;
    latency    = -1;
    busyCycles = 0;
    rkErrors   = 0;
    expIdx     = 31;
    ct_l  = cl;
    ct_r  = cr;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        latency = c;
        break;
      end
      if (busy) begin
        busyCycles++;
        if (int'(rk_idx) != expIdx) rkErrors++;
        expIdx--;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b1;
    start1 = 1'b1;
    tick();
    tick();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    testsRun++;
    if ({pt_l, pt_r} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pt: got %h expected 00000000", {pt_l, pt_r});
    end
    testsRun++;
    if (rk_idx !== 5'd31) begin
      testsFailed++;
      $display("[TB] FAIL reset_rk_idx: got %0d expected 31", rk_idx);
    end
    reset  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    tick();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_wins_over_start: busy %b expected 0", busy);
    end
  endtask

  task automatic test_known_answer();
    int lat, bc, rke;
    genKeys(64'h1918_1110_0908_0100);
    applyStimulus(16'h770d, 16'h2c76, lat, bc, rke);
    testsRun++;
    if (lat != 33) begin
      testsFailed++;
      $display("[TB] FAIL kat_latency: got %0d expected 33", lat);
    end
    testsRun++;
    if (bc != 32) begin
      testsFailed++;
      $display("[TB] FAIL kat_busy_cycles: got %0d expected 32", bc);
    end
    testsRun++;
    if (rke != 0) begin
      testsFailed++;
      $display("[TB] FAIL kat_rk_idx_sequence: got %0d wrong indices expected 0", rke);
    end
    testsRun++;
    if (pt_l !== 16'h6565) begin
      testsFailed++;
      $display("[TB] FAIL kat_pt_l: got %h expected 6565", pt_l);
    end
    testsRun++;
    if (pt_r !== 16'h6877) begin
      testsFailed++;
      $display("[TB] FAIL kat_pt_r: got %h expected 6877", pt_r);
    end
    tick();
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL kat_done_width: got %b expected 0", done);
    end
    repeat (3) tick();
    testsRun++;
    if ({pt_l, pt_r} !== 32'h6565_6877) begin
      testsFailed++;
      $display("[TB] FAIL kat_pt_hold: got %h expected 65656877", {pt_l, pt_r});
    end
  endtask

  task automatic test_single_round();
    ct1_l  = 16'h0001;
    ct1_r  = 16'h0000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    testsRun++;
    if ({busy1, done1} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL single_first_edge: busy,done got %b expected 10", {busy1, done1});
    end
    testsRun++;
    if (rkIdx1 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_rk_idx: got %0d expected 0", rkIdx1);
    end
    tick();
    testsRun++;
    if ({busy1, done1} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL single_done_edge: busy,done got %b expected 01", {busy1, done1});
    end
    testsRun++;
    if ({pt1_l, pt1_r} !== 32'h0000_0001) begin
      testsFailed++;
      $display("[TB] FAIL single_pt: got %h expected 00000001", {pt1_l, pt1_r});
    end
  endtask

  task automatic test_round_trip();
    int lat, bc, rke;
    logic [15:0] pl, pr;
    logic [31:0] ct;
    for (int n = 0; n < 100; n++) begin
      genKeys({$urandom(), $urandom()});
      pl = 16'($urandom());
      pr = 16'($urandom());
      ct = encryptRef(pl, pr);
      applyStimulus(ct[31:16], ct[15:0], lat, bc, rke);
      testsRun++;
      if (lat != 33) begin
        testsFailed++;
        $display("[TB] FAIL rt_latency[%0d]: got %0d expected 33", n, lat);
      end
      testsRun++;
      if ({pt_l, pt_r} !== {pl, pr}) begin
        testsFailed++;
        $display("[TB] FAIL rt_plaintext[%0d]: got %h expected %h", n, {pt_l, pt_r}, {pl, pr});
      end
      tick();
      testsRun++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL rt_single_done[%0d]: busy,done got %b expected 00", n, {busy, done});
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] pl, pr;
    logic [31:0] ctA;
    int doneCnt, firstDone;
    genKeys({$urandom(), $urandom()});
    pl  = 16'($urandom());
    pr  = 16'($urandom());
    ctA = encryptRef(pl, pr);
    doneCnt   = 0;
    firstDone = -1;
    ct_l  = ctA[31:16];
    ct_r  = ctA[15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (done) begin
        doneCnt++;
        if (firstDone < 0) firstDone = c;
      end
      if (c == 10) begin
        ct_l  = ~ctA[31:16];
        ct_r  = ctA[15:0] ^ 16'h5a5a;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    testsRun++;
    if (doneCnt != 1) begin
      testsFailed++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCnt);
    end
    testsRun++;
    if (firstDone != 33) begin
      testsFailed++;
      $display("[TB] FAIL ignore_latency: got %0d expected 33", firstDone);
    end
    testsRun++;
    if ({pt_l, pt_r} !== {pl, pr}) begin
      testsFailed++;
      $display("[TB] FAIL ignore_result: got %h expected %h", {pt_l, pt_r}, {pl, pr});
    end
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_no_restart: busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, rke, doneCnt;
    genKeys(64'h1918_1110_0908_0100);
    ct_l  = 16'h770d;
    ct_r  = 16'h2c76;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    testsRun++;
    if ({busy, done} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL midreset_flags: busy,done got %b expected 00", {busy, done});
    end
    testsRun++;
    if ({pt_l, pt_r} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_pt: got %h expected 00000000", {pt_l, pt_r});
    end
    testsRun++;
    if (rk_idx !== 5'd31) begin
      testsFailed++;
      $display("[TB] FAIL midreset_rk_idx: got %0d expected 31", rk_idx);
    end
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) doneCnt++;
      tick();
    end
    testsRun++;
    if (doneCnt != 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", doneCnt);
    end
    applyStimulus(16'h770d, 16'h2c76, lat, bc, rke);
    testsRun++;
    if (lat != 33 || {pt_l, pt_r} !== 32'h6565_6877) begin
      testsFailed++;
      $display("[TB] FAIL midreset_rerun: latency %0d pt %h expected 33 65656877", lat, {pt_l, pt_r});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc, rke, holdErr, lat2;
    logic [15:0] al, ar, bl, br;
    logic [31:0] ctA, ctB;
    genKeys({$urandom(), $urandom()});
    al  = 16'($urandom());
    ar  = 16'($urandom());
    bl  = 16'($urandom());
    br  = ~al;
    ctA = encryptRef(al, ar);
    ctB = encryptRef(bl, br);
    applyStimulus(ctA[31:16], ctA[15:0], lat, bc, rke);
    testsRun++;
    if (lat != 33 || {pt_l, pt_r} !== {al, ar}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: latency %0d pt %h expected 33 %h", lat, {pt_l, pt_r}, {al, ar});
    end
    ct_l  = ctB[31:16];
    ct_r  = ctB[15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    testsRun++;
    if ({busy, done} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL b2b_no_gap: busy,done got %b expected 10", {busy, done});
    end
    holdErr = 0;
    lat2    = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat2 = c;
        break;
      end
      if ({pt_l, pt_r} !== {al, ar}) holdErr++;
      tick();
    end
    testsRun++;
    if (holdErr != 0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_hold: got %0d cycles with changed pt expected 0", holdErr);
    end
    testsRun++;
    if (lat2 != 33) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_latency: got %0d expected 33", lat2);
    end
    testsRun++;
    if ({pt_l, pt_r} !== {bl, br}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_pt: got %h expected %h", {pt_l, pt_r}, {bl, br});
    end
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    ct_l   = '0;
    ct_r   = '0;
    ct1_l  = '0;
    ct1_r  = '0;
    for (int i = 0; i < 32; i++) rkStore[i] = '0;
    #1;
    test_reset();
    test_known_answer();
    test_single_round();
    test_round_trip();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
